// File: rtl/debug_uart_tx_hex.sv
// Debug trace UART transmitter: prints each accepted 32-bit word as eight
// uppercase hex digits followed by CR LF, 8N1, LSB first.
module debug_uart_tx_hex #(
  parameter int CLK_FREQUENCY = 50_000_000,
  parameter int BAUD_RATE     = 115200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        word_valid,
  output logic        word_ready,
  input  logic [31:0] word_data,
  output logic        txd,
  output logic        busy
);

  localparam int DIV = CLK_FREQUENCY / BAUD_RATE;
  localparam int BW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);

  if (DIV < 2) begin : g_div_check
    $error("debug_uart_tx_hex: CLK_FREQUENCY/BAUD_RATE must be at least 2");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [3:0]      chr_q, chr_d;
  logic [31:0]     word_q, word_d;
  logic            txd_q, txd_d;
  logic            bit_end;
  logic [7:0]      cur_char;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Character index 0..7 walks nibbles MSB first; 8 and 9 are CR LF.
  function automatic logic [7:0] char_at(input logic [31:0] w, input logic [3:0] idx);
    logic [31:0] sh;
    sh = w << {idx[2:0], 2'b00};
    case (idx)
      4'd8:    return 8'h0D;
      4'd9:    return 8'h0A;
      default: return hex_ascii(sh[31:28]);
    endcase
  endfunction

  assign bit_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    chr_d   = chr_q;
    word_d  = word_q;
    case (state_q)
      IDLE: begin
        if (word_valid) begin
          word_d  = word_data;
          chr_d   = 4'd0;
          bit_d   = 3'd0;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_d = '0;
          bit_d  = 3'd0;
          if (chr_q == 4'd9) begin
            state_d = IDLE;
          end else begin
            chr_d   = chr_q + 4'd1;
            state_d = START;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // txd is registered from the next-state view so the line level changes on
  // the same edge as the state, keeping every bit exactly DIV cycles long.
  always_comb begin
    cur_char = char_at(word_d, chr_d);
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = cur_char[bit_d];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      chr_q   <= 4'd0;
      word_q  <= 32'h0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      chr_q   <= chr_d;
      word_q  <= word_d;
      txd_q   <= txd_d;
    end
  end

  assign word_ready = (state_q == IDLE);
  assign busy       = ~word_ready;
  assign txd        = txd_q;

endmodule

// File: tb/tb_debug_uart_tx_hex.sv
// Bench for debug_uart_tx_hex: DIV=16 instance for frame content and timing,
// default-parameter instance for the full-length frame.
module tb_debug_uart_tx_hex;

  logic        clk = 1'b0;
  logic        reset;
  logic        va, vb;
  logic [31:0] da, db;
  logic        ra, rb, ta, tb_x, ba, bb;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  debug_uart_tx_hex #(.CLK_FREQUENCY(16), .BAUD_RATE(1)) u_a (
    .clk(clk), .reset(reset), .word_valid(va), .word_ready(ra),
    .word_data(da), .txd(ta), .busy(ba)
  );

  debug_uart_tx_hex u_b (
    .clk(clk), .reset(reset), .word_valid(vb), .word_ready(rb),
    .word_data(db), .txd(tb_x), .busy(bb)
  );

  typedef struct {
    logic [31:0] w;
    logic [79:0] exp;
    bit          poke;
  } vec_t;

  vec_t vt[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Caller has set valid/data before the edge that becomes edge 0. Every
  // cycle of the frame is checked against the expected line level, each
  // character is decoded at mid-bit, and ready is checked in the idle cycle.
  task automatic run_frame(input bit sel, input int div, input logic [79:0] exp,
                           input bit hold, input logic [31:0] next_data,
                           input bit poke, input string tag);
    int errs = 0;
    int first = -1;
    int b, k;
    logic [79:0] tmp;
    logic [7:0]  ch, rx;
    logic        t, r, expbit;
    rx = 8'h00;
    @(posedge clk);
    for (int c = 1; c <= 100 * div; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (hold) begin
          if (sel) db = next_data; else da = next_data;
        end else begin
          if (sel) vb = 1'b0; else va = 1'b0;
        end
      end
      if (poke && c == div * 37)     begin da = 32'hDEADBEEF; va = 1'b1; end
      if (poke && c == div * 37 + 3) va = 1'b0;
      t = sel ? tb_x : ta;
      r = sel ? rb : ra;
      b = ((c - 1) / div) % 10;
      k = (c - 1) / (10 * div);
      tmp = exp << (8 * k);
      ch  = tmp[79:72];
      expbit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : ch[b - 1];
      if (t !== expbit || r !== 1'b0) begin
        errs++;
        if (first < 0) first = c;
      end
      if ((c - 1) % div == div / 2) begin
        if (b >= 1 && b <= 8) rx[b - 1] = t;
        if (b == 9) chk($sformatf("%s char%0d", tag, k), {24'h0, rx}, {24'h0, ch});
      end
    end
    chk($sformatf("%s per-cycle txd/ready errors (first at cycle %0d)", tag, first), errs, 0);
    @(negedge clk);
    chk($sformatf("%s ready in idle cycle", tag), {31'h0, sel ? rb : ra}, 32'd1);
    chk($sformatf("%s txd in idle cycle", tag), {31'h0, sel ? tb_x : ta}, 32'd1);
  endtask

  initial begin
    vt[0] = '{32'h1234ABCD, "1234ABCD\r\n", 1'b0};
    vt[1] = '{32'h89ABCDEF, "89ABCDEF\r\n", 1'b1};
    vt[2] = '{32'h9A0F5E3C, "9A0F5E3C\r\n", 1'b0};

    reset = 1'b1;
    va = 1'b0; vb = 1'b0;
    da = 32'h0; db = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset txd", {31'h0, ta}, 32'd1);
    chk("reset ready", {31'h0, ra}, 32'd1);
    chk("reset busy", {31'h0, ba}, 32'd0);
    chk("reset txd dflt", {31'h0, tb_x}, 32'd1);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      va = 1'b1;
      da = vt[i].w;
      run_frame(1'b0, 16, vt[i].exp, 1'b0, 32'h0, vt[i].poke, $sformatf("vec%0d", i));
    end

    // Back to back with valid held: second start bit lands in cycle 1602.
    va = 1'b1;
    da = 32'h00000000;
    run_frame(1'b0, 16, "00000000\r\n", 1'b1, 32'hFFFFFFFF, 1'b0, "b2b0");
    run_frame(1'b0, 16, "FFFFFFFF\r\n", 1'b0, 32'h0, 1'b0, "b2b1");

    // Abort during DATA bit 0 of character 3 ('4' = 0x34, bit0 = 0).
    @(negedge clk);
    va = 1'b1;
    da = 32'h12345678;
    @(posedge clk);
    for (int c = 1; c <= 505; c++) begin
      @(negedge clk);
      if (c == 1) va = 1'b0;
    end
    chk("pre-abort txd", {31'h0, ta}, 32'd0);
    chk("pre-abort busy", {31'h0, ba}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async reset txd", {31'h0, ta}, 32'd1);
    chk("async reset ready", {31'h0, ra}, 32'd1);
    chk("async reset busy", {31'h0, ba}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    va = 1'b1;
    da = 32'h0000000F;
    run_frame(1'b0, 16, "0000000F\r\n", 1'b0, 32'h0, 1'b0, "post-reset");

    vb = 1'b1;
    db = 32'hA5A5A5A5;
    run_frame(1'b1, 434, "A5A5A5A5\r\n", 1'b0, 32'h0, 1'b0, "dflt");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
